// File: rtl/ins_dec_pipe.sv
// rtl/ins_dec_pipe.sv - registered instruction-decode stage with RAW hazard stall and jump squash
//
// Purpose: splits a (2*DW+3)-bit instruction into control bits and operand
// fields. Valid/ready handshakes are used on both sides, and one output
// register holds the decode. The stage stalls readers that depend on recently
// issued writes, and it discards the FLUSH instructions that follow an
// accepted jump.
//
// Build option: define INS_DEC_HAZARD_EN to compile in the write scoreboard
// and the hazard stall. When it is undefined, hazard is tied to 0.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  upstream handshake; INS is the instruction
//   out_valid/out_ready  downstream handshake for the registered fields
//   sel_data, write_en, alu_op, is_jmp   decoded control bits
//   SEL_A, SEL_B, SEL_W  register selects (RW bits)
//   IMM, JMP             immediate and jump target (DW bits)
module ins_dec_pipe #(
  parameter int DW        = 4,
  parameter int RW        = 2,
  parameter int HAZ_DEPTH = 2,
  parameter int FLUSH     = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW+2:0] INS,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            sel_data,
  output logic            write_en,
  output logic            alu_op,
  output logic            is_jmp,
  output logic [RW-1:0]   SEL_A,
  output logic [RW-1:0]   SEL_B,
  output logic [RW-1:0]   SEL_W,
  output logic [DW-1:0]   IMM,
  output logic [DW-1:0]   JMP
);

  localparam int IW  = 2*DW+3;
  // Keep the squash counter at least 1 bit wide so FLUSH=0 still elaborates.
  localparam int SCW = (FLUSH < 1) ? 1 : $clog2(FLUSH+1);
  localparam logic [SCW-1:0] FLUSH_LD = SCW'(FLUSH);

  // Combinational decode of the incoming instruction
  logic [2:0]    op;
  logic          d_sel_data;
  logic          d_alu_op;
  logic          d_is_jmp;
  logic          d_write_en;
  logic [RW-1:0] d_sel_a;
  logic [RW-1:0] d_sel_b;
  logic [RW-1:0] d_sel_w;
  logic [DW-1:0] d_imm;
  logic [DW-1:0] d_jmp;

  assign op         = INS[IW-1:2*DW];
  assign d_sel_data = op[1];
  assign d_alu_op   = op[0];
  assign d_is_jmp   = (op == 3'b100);
  assign d_write_en = !((op == 3'b011) || d_is_jmp);
  assign d_imm      = INS[DW-1:0];
  assign d_sel_b    = INS[RW-1:0];
  assign d_sel_a    = INS[2*RW-1:RW];
  assign d_sel_w    = INS[DW+RW-1:DW];
  assign d_jmp      = INS[2*DW-1:DW];

  logic [SCW-1:0] squash_cnt;
  logic           squashing;
  logic           hazard;
  logic           accept;
  logic           keep;

  assign squashing = (squash_cnt != '0);
  assign in_ready  = rst_n && (!out_valid || out_ready) && !hazard;
  assign accept    = in_valid && in_ready;
  // Only non-squashed accepts reach the output register and scoreboard.
  assign keep      = accept && !squashing;

`ifdef INS_DEC_HAZARD_EN
  logic                 reads;
  logic                 stall;
  logic [HAZ_DEPTH-1:0] sb_v;
  logic [RW-1:0]        sb_sel [HAZ_DEPTH];

  assign reads = !d_sel_data && !d_is_jmp;
  // Entries age only in cycles where the output register moves, so the
  // hazard window is measured in unstalled cycles.
  assign stall = out_valid && !out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_v <= '0;
      for (int i = 0; i < HAZ_DEPTH; i++) begin
        sb_sel[i] <= '0;
      end
    end else if (!stall) begin
      sb_v[0]   <= keep && d_write_en;
      sb_sel[0] <= (keep && d_write_en) ? d_sel_w : '0;
      for (int i = 1; i < HAZ_DEPTH; i++) begin
        sb_v[i]   <= sb_v[i-1];
        sb_sel[i] <= sb_sel[i-1];
      end
    end
  end

  // A squashed instruction is dropped anyway, so it never waits on a hazard.
  always_comb begin
    hazard = 1'b0;
    if (in_valid && reads && !squashing) begin
      for (int i = 0; i < HAZ_DEPTH; i++) begin
        if (sb_v[i] && ((sb_sel[i] == d_sel_a) || (sb_sel[i] == d_sel_b))) begin
          hazard = 1'b1;
        end
      end
    end
  end
`else
  assign hazard = 1'b0;
`endif

  // Squash counter: a kept jump arms it; every accept while armed counts down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      squash_cnt <= '0;
    end else if (accept) begin
      if (squashing) begin
        squash_cnt <= squash_cnt - SCW'(1);
      end else if (d_is_jmp) begin
        squash_cnt <= FLUSH_LD;
      end
    end
  end

  // Output register: reload on a kept accept (even while draining),
  // clear on drain without reload, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sel_data  <= 1'b0;
      write_en  <= 1'b0;
      alu_op    <= 1'b0;
      is_jmp    <= 1'b0;
      SEL_A     <= '0;
      SEL_B     <= '0;
      SEL_W     <= '0;
      IMM       <= '0;
      JMP       <= '0;
    end else if (keep) begin
      out_valid <= 1'b1;
      sel_data  <= d_sel_data;
      write_en  <= d_write_en;
      alu_op    <= d_alu_op;
      is_jmp    <= d_is_jmp;
      SEL_A     <= d_sel_a;
      SEL_B     <= d_sel_b;
      SEL_W     <= d_sel_w;
      IMM       <= d_imm;
      JMP       <= d_jmp;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/ins_dec_pipe.md
# ins_dec_pipe

Registered, parametrised instruction-decode stage for the 4-bit CPU family, placed between fetch and the register file/ALU. It splits a (2·DW+3)-bit instruction into control bits and operand fields. Unlike the purely combinational decoder, it uses valid/ready handshakes on both sides and holds one output register. It also stalls on read-after-write hazards against recently issued writes and squashes the branch shadow after a jump.

## Interface
Parameters:
- DW, 4: data/immediate width; also the jump-target width.
- RW, 2: register-select width; 2·RW ≤ DW is required.
- HAZ_DEPTH, 2: scoreboard entries, i.e. cycles until a write is visible; ≥1.
- FLUSH, 1: number of instructions squashed after a jump; 0 disables squashing.

Ports (IW = 2·DW+3):
- clk  in  1  sole clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  INS is valid.
- in_ready  out  1  stage accepts INS this cycle.
- INS  in  IW  instruction.
- out_valid  out  1  decoded fields are valid.
- out_ready  in  1  downstream consumes this cycle.
- sel_data  out  1  1 selects IMM, 0 selects register B.
- write_en  out  1  register-file write enable.
- alu_op  out  1  ALU operation select.
- is_jmp  out  1  instruction is a jump.
- SEL_A  out  RW  source A.
- SEL_B  out  RW  source B.
- SEL_W  out  RW  destination.
- IMM  out  DW  immediate.
- JMP  out  DW  jump target.

## Operation
- Field map, with OP = INS[2DW+2:2DW]:
  - sel_data = OP[1], alu_op = OP[0].
  - IMM = INS[DW-1:0], SEL_B = INS[RW-1:0], SEL_A = INS[2RW-1:RW].
  - SEL_W = INS[DW+RW-1:DW], JMP = INS[2DW-1:DW].
- write_en = 0 for OP 3'b011 and 3'b100, 1 otherwise. is_jmp = (OP == 3'b100).
- Source read: reads = !sel_data && !is_jmp. Such an instruction reads SEL_A and SEL_B.
- Accept: accept occurs when in_valid && in_ready. The decode is captured into the output register and out_valid is set.
- Output register handshake:
  - The register clears when out_valid && out_ready and no new accept occurs.
  - Accept and drain in the same cycle is allowed; the output reloads.
  - Fields are held stable while out_valid && !out_ready.
- in_ready = rst_n && (!out_valid || out_ready) && !hazard.
- Scoreboard: a HAZ_DEPTH-entry shift register of {v, sel}.
  - It advances on every cycle except stalls, where a stall is out_valid && !out_ready.
  - entry[0] loads {1, SEL_W} when a writing instruction is accepted. Otherwise entry[0] loads v = 0.
  - The oldest entry drops off the end.
- hazard = in_valid && reads && a valid entry matches SEL_A or SEL_B. Hazard is forced to 0 while squashing.
- Squash:
  - Accepting a jump loads squash_cnt with FLUSH.
  - While squash_cnt ≠ 0, accepted instructions are discarded: out_valid is not set and no scoreboard insert occurs. Each accept decrements squash_cnt.
  - A jump accepted during squash is discarded and does not reload squash_cnt.

## Timing
- Latency is 1 cycle from accept to out_valid.
- On reset, out_valid=0 and all field outputs, squash_cnt and scoreboard entries are 0. in_ready is 0 while rst_n=0.
- Reset mid-operation clears the held instruction, pending hazards and squash state immediately. No partial output is produced.
- Combinational paths exist from out_ready, in_valid and INS to in_ready. Outputs are registered.
- A write issued in cycle t blocks dependent readers through cycle t+HAZ_DEPTH, counted in unstalled cycles.

## Configuration
- INS_DEC_HAZARD_EN defined: the scoreboard and hazard stall are compiled in.
- Not defined: hazard is tied to 0 and the scoreboard is not built. Dependent instructions issue back-to-back. Squash behaviour is unchanged.

## Test plan
All scenarios use DW=4, RW=2, HAZ_DEPTH=2, FLUSH=1 and INS_DEC_HAZARD_EN defined, unless stated.
- Reset: hold rst_n=0 with in_valid=1 -> in_ready=0, out_valid=0, all fields 0. Release -> in_ready=1.
- Field decode: INS=11'h02D with out_ready=1 -> next cycle out_valid=1, sel_data=0, alu_op=0, write_en=1, is_jmp=0, SEL_A=3, SEL_B=1, SEL_W=2, IMM=0xD, JMP=0x2.
- Write enable and jump: INS=11'h3FF -> write_en=0, sel_data=1, alu_op=1. INS=11'h4A0 -> write_en=0, is_jmp=1, JMP=0xA.
- Hazard: INS=11'h020 then 11'h008 -> in_ready=0 for exactly 2 cycles, then 11'h008 is accepted. With the macro undefined, 11'h008 is accepted on the next cycle.
- Squash: INS=11'h4A0, 11'h010, 11'h020 back-to-back -> outputs are the jump, then 11'h020. 11'h010 produces no out_valid and does not occupy the scoreboard.
- Backpressure: out_ready=0 for 3 cycles after 11'h020 -> fields stable and in_ready=0. The scoreboard does not age, so a dependent 11'h008 still waits 2 cycles after out_ready returns to 1.
